// File: rtl/cal_pkg.sv
// Shared types for the calibration frequency-counter slice.
// Holds the FSM state and owner encodings plus the default counter width.
package cal_pkg;

    localparam int CNT_W_DEF = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } cal_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_AFC   = 2'd1,
        OWN_LOGEN = 2'd2
    } cal_owner_e;

endpackage

// File: rtl/cal_cntr_resp_if.sv
// Request/response bundle between the AFC/LOGEN cal FSMs and the counter.
// master: the requesting side (drives requests); slave: cal_cntr_resp.
interface cal_cntr_resp_if #(
    parameter int CNT_W = cal_pkg::CNT_W_DEF
);
    logic             afc_cntr_rstn;
    logic             afc_cntr_en;
    logic             afc_cntr_datasyn;
    logic             logen_cntr_rstn;
    logic             logen_cntr_en;
    logic             logen_cntr_datasyn;
    logic [CNT_W-1:0] a2d_ncntr;
    logic             ncntr_vld;
    logic             ncntr_ovf;
    logic [1:0]       cntr_owner;
    logic             cntr_conflict;

    modport master (
        output afc_cntr_rstn, afc_cntr_en, afc_cntr_datasyn,
        output logen_cntr_rstn, logen_cntr_en, logen_cntr_datasyn,
        input  a2d_ncntr, ncntr_vld, ncntr_ovf,
        input  cntr_owner, cntr_conflict
    );

    modport slave (
        input  afc_cntr_rstn, afc_cntr_en, afc_cntr_datasyn,
        input  logen_cntr_rstn, logen_cntr_en, logen_cntr_datasyn,
        output a2d_ncntr, ncntr_vld, ncntr_ovf,
        output cntr_owner, cntr_conflict
    );
endinterface

// File: rtl/cal_sync_edge.sv
// SYNC_STG-flop synchronizer plus rising-edge detect for an async input.
// Ports: clk, rstn (async low), din (async), rise (1-clk pulse per din rise).
module cal_sync_edge #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic rise
);

    logic [SYNC_STG-1:0] sync_q;
    logic                s_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], din};
            s_d    <= sync_q[SYNC_STG-1];
        end
    end

    assign rise = sync_q[SYNC_STG-1] & ~s_d;

endmodule

// File: rtl/cal_cntr_resp.sv
// Shared cal frequency counter: arbitrates AFC/LOGEN, counts fdiv_in rises.
// Ports: clk, rstn, fdiv_in (async), bus (slave side of cal_cntr_resp_if).
module cal_cntr_resp
    import cal_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic fdiv_in,
    cal_cntr_resp_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cal_state_e       state_q;
    cal_owner_e       owner_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_int_q;
    logic [CNT_W-1:0] a2d_q;
    logic             vld_q;
    logic             ovf_q;
    logic             conflict_q;
    logic             afc_ds_q, logen_ds_q;
    logic             afc_en_q, logen_en_q;

    logic fdiv_rise;
    logic o_rstn, o_en, o_ds, o_ds_q, o_en_q;
    logic nown_req;
    logic ds_rise, en_rise;

    cal_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .din  (fdiv_in),
        .rise (fdiv_rise)
    );

    // Owner-side view of the handshake; non-owner activity only feeds
    // the conflict flag.
    always_comb begin
        o_rstn   = 1'b1;
        o_en     = 1'b0;
        o_ds     = 1'b0;
        o_ds_q   = 1'b0;
        o_en_q   = 1'b0;
        nown_req = 1'b0;
        unique case (owner_q)
            OWN_AFC: begin
                o_rstn   = bus.afc_cntr_rstn;
                o_en     = bus.afc_cntr_en;
                o_ds     = bus.afc_cntr_datasyn;
                o_ds_q   = afc_ds_q;
                o_en_q   = afc_en_q;
                nown_req = bus.logen_cntr_en | bus.logen_cntr_datasyn;
            end
            OWN_LOGEN: begin
                o_rstn   = bus.logen_cntr_rstn;
                o_en     = bus.logen_cntr_en;
                o_ds     = bus.logen_cntr_datasyn;
                o_ds_q   = logen_ds_q;
                o_en_q   = logen_en_q;
                nown_req = bus.afc_cntr_en | bus.afc_cntr_datasyn;
            end
            default: ;
        endcase
    end

    assign ds_rise = o_ds & ~o_ds_q;
    assign en_rise = o_en & ~o_en_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            count_q    <= '0;
            ovf_int_q  <= 1'b0;
            a2d_q      <= '0;
            vld_q      <= 1'b0;
            ovf_q      <= 1'b0;
            conflict_q <= 1'b0;
            afc_ds_q   <= 1'b0;
            logen_ds_q <= 1'b0;
            afc_en_q   <= 1'b0;
            logen_en_q <= 1'b0;
        end else begin
            vld_q      <= 1'b0;
            afc_ds_q   <= bus.afc_cntr_datasyn;
            logen_ds_q <= bus.logen_cntr_datasyn;
            afc_en_q   <= bus.afc_cntr_en;
            logen_en_q <= bus.logen_cntr_en;

            if (nown_req) begin
                conflict_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    // AFC is tested first so it wins a same-cycle tie.
                    if (bus.afc_cntr_en && bus.afc_cntr_rstn) begin
                        owner_q   <= OWN_AFC;
                        count_q   <= '0;
                        ovf_int_q <= 1'b0;
                        state_q   <= COUNT;
                    end else if (bus.logen_cntr_en &&
                                 bus.logen_cntr_rstn) begin
                        owner_q   <= OWN_LOGEN;
                        count_q   <= '0;
                        ovf_int_q <= 1'b0;
                        state_q   <= COUNT;
                    end
                end
                COUNT: begin
                    if (!o_rstn) begin
                        owner_q   <= OWN_NONE;
                        count_q   <= '0;
                        ovf_int_q <= 1'b0;
                        a2d_q     <= '0;
                        ovf_q     <= 1'b0;
                        state_q   <= IDLE;
                    end else if (ds_rise) begin
                        // An edge seen this cycle is dropped on purpose.
                        a2d_q   <= count_q;
                        ovf_q   <= ovf_int_q;
                        vld_q   <= 1'b1;
                        state_q <= HOLD;
                    end else if (fdiv_rise && o_en) begin
                        if (count_q == CNT_MAX) begin
                            ovf_int_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!o_rstn) begin
                        owner_q   <= OWN_NONE;
                        count_q   <= '0;
                        ovf_int_q <= 1'b0;
                        a2d_q     <= '0;
                        ovf_q     <= 1'b0;
                        state_q   <= IDLE;
                    end else if (ds_rise) begin
                        a2d_q <= count_q;
                        ovf_q <= ovf_int_q;
                        vld_q <= 1'b1;
                    end else if (en_rise && !o_ds) begin
                        count_q   <= '0;
                        ovf_int_q <= 1'b0;
                        state_q   <= COUNT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a2d_ncntr     = a2d_q;
    assign bus.ncntr_vld     = vld_q;
    assign bus.ncntr_ovf     = ovf_q;
    assign bus.cntr_owner    = owner_q;
    assign bus.cntr_conflict = conflict_q;

endmodule

// File: tb/tb_cal_cntr_resp.sv
// Directed bench for cal_cntr_resp.
// Hand-computed expectations for claim, count, latch, saturation, arbitration.
module tb_cal_cntr_resp;

    localparam int CNT_W = 14;

    logic clk;
    logic rstn;
    logic fdiv_in;
    int   nchk;
    int   nerr;
    int   vld_cnt;
    int   v0;

    cal_cntr_resp_if #(.CNT_W(CNT_W)) bus ();

    cal_cntr_resp #(.CNT_W(CNT_W), .SYNC_STG(2)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .fdiv_in (fdiv_in),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ncntr_vld) vld_cnt <= vld_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n rises of fdiv_in, half clk high / half clk low, then let the
    // synchronizer drain.
    task automatic pulses(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            fdiv_in = 1'b1;
            repeat (half) tick();
            fdiv_in = 1'b0;
            repeat (half) tick();
        end
        repeat (4) tick();
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        vld_cnt = 0;
        rstn = 1'b0;
        fdiv_in = 1'b0;
        bus.afc_cntr_rstn = 1'b1;
        bus.afc_cntr_en = 1'b0;
        bus.afc_cntr_datasyn = 1'b0;
        bus.logen_cntr_rstn = 1'b1;
        bus.logen_cntr_en = 1'b0;
        bus.logen_cntr_datasyn = 1'b0;
        repeat (3) tick();
        chk("rst_a2d", int'(bus.a2d_ncntr), 0);
        chk("rst_vld", int'(bus.ncntr_vld), 0);
        chk("rst_ovf", int'(bus.ncntr_ovf), 0);
        chk("rst_owner", int'(bus.cntr_owner), 0);
        chk("rst_conf", int'(bus.cntr_conflict), 0);
        rstn = 1'b1;
        tick();

        // Basic AFC measurement, datasyn held 10 clk
        bus.afc_cntr_en = 1'b1;
        tick();
        chk("basic_owner", int'(bus.cntr_owner), 1);
        pulses(100, 4);
        bus.afc_cntr_en = 1'b0;
        tick();
        v0 = vld_cnt;
        bus.afc_cntr_datasyn = 1'b1;
        tick();
        chk("basic_a2d", int'(bus.a2d_ncntr), 100);
        chk("basic_vld", int'(bus.ncntr_vld), 1);
        chk("basic_ovf", int'(bus.ncntr_ovf), 0);
        tick();
        chk("basic_vld_drop", int'(bus.ncntr_vld), 0);
        repeat (8) tick();
        chk("ds_held_pulses", vld_cnt - v0, 1);
        bus.afc_cntr_datasyn = 1'b0;
        tick();

        // Re-measure from HOLD
        bus.afc_cntr_en = 1'b1;
        tick();
        pulses(7, 4);
        bus.afc_cntr_en = 1'b0;
        tick();
        bus.afc_cntr_datasyn = 1'b1;
        tick();
        chk("remeas_a2d", int'(bus.a2d_ncntr), 7);
        chk("remeas_owner", int'(bus.cntr_owner), 1);
        bus.afc_cntr_datasyn = 1'b0;
        tick();

        // Mid-count clear
        bus.afc_cntr_en = 1'b1;
        tick();
        pulses(40, 4);
        v0 = vld_cnt;
        bus.afc_cntr_rstn = 1'b0;
        tick();
        chk("clr_a2d", int'(bus.a2d_ncntr), 0);
        chk("clr_owner", int'(bus.cntr_owner), 0);
        bus.afc_cntr_rstn = 1'b1;
        tick();
        chk("clr_novld", vld_cnt - v0, 0);
        chk("reclaim_owner", int'(bus.cntr_owner), 1);
        pulses(25, 4);
        bus.afc_cntr_en = 1'b0;
        tick();
        bus.afc_cntr_datasyn = 1'b1;
        tick();
        chk("reclaim_a2d", int'(bus.a2d_ncntr), 25);
        bus.afc_cntr_datasyn = 1'b0;
        tick();

        // Saturation
        bus.afc_cntr_en = 1'b1;
        tick();
        pulses(20000, 1);
        bus.afc_cntr_en = 1'b0;
        tick();
        bus.afc_cntr_datasyn = 1'b1;
        tick();
        chk("sat_a2d", int'(bus.a2d_ncntr), 16383);
        chk("sat_ovf", int'(bus.ncntr_ovf), 1);
        chk("sat_vld", int'(bus.ncntr_vld), 1);
        bus.afc_cntr_datasyn = 1'b0;
        bus.afc_cntr_rstn = 1'b0;
        tick();
        chk("sat_clr_a2d", int'(bus.a2d_ncntr), 0);
        chk("sat_clr_ovf", int'(bus.ncntr_ovf), 0);
        chk("sat_clr_owner", int'(bus.cntr_owner), 0);
        bus.afc_cntr_rstn = 1'b1;
        tick();

        // Arbitration tie
        bus.afc_cntr_en = 1'b1;
        bus.logen_cntr_en = 1'b1;
        tick();
        chk("tie_owner", int'(bus.cntr_owner), 1);
        tick();
        chk("tie_conflict", int'(bus.cntr_conflict), 1);
        v0 = vld_cnt;
        bus.logen_cntr_datasyn = 1'b1;
        repeat (2) tick();
        chk("tie_logen_novld", vld_cnt - v0, 0);
        bus.logen_cntr_datasyn = 1'b0;
        bus.afc_cntr_rstn = 1'b0;
        tick();
        chk("tie_rel_owner", int'(bus.cntr_owner), 0);
        bus.afc_cntr_rstn = 1'b1;
        bus.afc_cntr_en = 1'b0;
        tick();
        chk("tie_logen_owner", int'(bus.cntr_owner), 2);
        bus.logen_cntr_en = 1'b0;
        bus.logen_cntr_rstn = 1'b0;
        tick();
        chk("logen_rel", int'(bus.cntr_owner), 0);
        bus.logen_cntr_rstn = 1'b1;
        tick();

        // Async reset during COUNT
        bus.afc_cntr_en = 1'b1;
        tick();
        pulses(10, 4);
        bus.afc_cntr_en = 1'b0;
        tick();
        bus.afc_cntr_datasyn = 1'b1;
        tick();
        chk("pre_arst_a2d", int'(bus.a2d_ncntr), 10);
        bus.afc_cntr_datasyn = 1'b0;
        bus.afc_cntr_en = 1'b1;
        tick();
        pulses(3, 4);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_a2d", int'(bus.a2d_ncntr), 0);
        chk("arst_owner", int'(bus.cntr_owner), 0);
        chk("arst_conf", int'(bus.cntr_conflict), 0);
        chk("arst_vld", int'(bus.ncntr_vld), 0);
        v0 = vld_cnt;
        bus.afc_cntr_en = 1'b0;
        #3;
        rstn = 1'b1;
        repeat (5) tick();
        chk("arst_novld", vld_cnt - v0, 0);
        chk("arst_idle_owner", int'(bus.cntr_owner), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
